// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and shift-amount width for the iterative execute ALU.
package alu_pkg;

  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/exec_alu_if.sv
// Operand/result handshake bundle between operand select, the ALU and writeback.
interface exec_alu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      aluOp;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, aluOp, opA, opB, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, aluOp, opA, opB, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_shift_step.sv
// Combinational single-position shift used by the bit-serial shifter.
module alu_shift_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_value,
  input  logic            i_right,
  input  logic            i_arith,
  output logic [XLEN-1:0] o_value
);

  always_comb begin
    if (i_right) begin
      o_value = {i_arith & i_value[XLEN-1], i_value[XLEN-1:1]};
    end else begin
      o_value = {i_value[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exec_alu.sv
// Iterative RV32I execute ALU: single-cycle arithmetic/logic, bit-serial shifts, registered result.
module exec_alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst_n,
  input logic        flush,
  exec_alu_if.slave  bus
);

  alu_state_e         r_state;
  alu_state_e         w_state_next;
  logic [XLEN-1:0]    r_result;
  logic               r_zero;
  logic [XLEN-1:0]    r_shift;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_right;
  logic               r_arith;
  logic [XLEN-1:0]    w_alu_result;
  logic [XLEN-1:0]    w_step;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_accept;
  logic               w_serial;
  logic               w_last;

  assign w_shamt  = bus.opB[SHAMT_W-1:0];
  assign w_accept = bus.in_valid && (r_state == StIdle);
  assign w_serial = is_shift_op(bus.aluOp) && (w_shamt != '0);
  assign w_last   = (r_cnt == SHAMT_W'(1));

  // Shifts reach this path only with shamt 0, so they pass opA through.
  always_comb begin
    w_alu_result = '0;
    unique case (bus.aluOp)
      ALU_ADD:  w_alu_result = bus.opA + bus.opB;
      ALU_SUB:  w_alu_result = bus.opA - bus.opB;
      ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(bus.opA) < $signed(bus.opB)};
      ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, bus.opA < bus.opB};
      ALU_XOR:  w_alu_result = bus.opA ^ bus.opB;
      ALU_OR:   w_alu_result = bus.opA | bus.opB;
      ALU_AND:  w_alu_result = bus.opA & bus.opB;
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_result = bus.opA;
      default:  w_alu_result = '0;
    endcase
  end

  alu_shift_step #(
    .XLEN (XLEN)
  ) u_shift_step (
    .i_value (r_shift),
    .i_right (r_right),
    .i_arith (r_arith),
    .o_value (w_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_accept) w_state_next = w_serial ? StShift : StDone;
        StShift: if (w_last) w_state_next = StDone;
        StDone:  if (bus.out_ready) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (r_state == StIdle);
    bus.out_valid = (r_state == StDone);
    bus.result    = r_result;
    bus.zero      = r_zero;
  end

  // Flush leaves result/zero untouched; only the FSM drops the op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_right  <= 1'b0;
      r_arith  <= 1'b0;
    end else if (!flush) begin
      if (r_state == StIdle && w_accept) begin
        if (w_serial) begin
          r_shift <= bus.opA;
          r_cnt   <= w_shamt;
          r_right <= bus.aluOp[2];
          r_arith <= bus.aluOp[3];
        end else begin
          r_result <= w_alu_result;
          r_zero   <= (w_alu_result == '0);
        end
      end else if (r_state == StShift) begin
        r_shift <= w_step;
        r_cnt   <= r_cnt - SHAMT_W'(1);
        if (w_last) begin
          r_result <= w_step;
          r_zero   <= (w_step == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_alu.sv
// Randomized self-checking bench for exec_alu against an arithmetic reference model.
module tb_exec_alu;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_fail;

  exec_alu_if #(.XLEN(32)) bus ();

  exec_alu #(
    .XLEN (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return $signed(a) >>> sh;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0001 || op == 4'b0101 || op == 4'b1101) return int'(b % 32) + 1;
    return 1;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    exp_r   = ref_alu(op, a, b);
    exp_lat = ref_lat(op, b);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.aluOp    = op;
    bus.opA      = a;
    bus.opB      = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.aluOp    = 4'($urandom);
    bus.opA      = $urandom;
    bus.opB      = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", bus.result, exp_r);
    check("zero", 32'(bus.zero), 32'(exp_r == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", bus.result, exp_r);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] b;
    logic [31:0] res_before;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.aluOp     = '0;
    bus.opA       = '0;
    bus.opB       = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(4'b1000, 32'h1234, 32'h1234, 0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b1101, 32'h8000_0000, 32'd31, 0);
    run_op(4'b0001, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0);
    run_op(4'b0110, 32'hA5A5_0000, 32'h0000_5A5A, 5);
    run_op(4'b1001, 32'h1111_1111, 32'h2222_2222, 1);

    // Flush on cycle 3 of SRL by 10
    bus.in_valid = 1'b1;
    bus.aluOp    = 4'b0101;
    bus.opA      = 32'hFFFF_0000;
    bus.opB      = 32'd10;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    repeat (12) begin
      @(negedge clk);
      check("flush_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(4'b0000, 32'd100, 32'd23, 0);

    // Flush in idle blocks accept
    res_before   = bus.result;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.aluOp    = 4'b0000;
    bus.opA      = 32'd5;
    bus.opB      = 32'd6;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("idle_flush_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("idle_flush_valid", 32'(bus.out_valid), 32'd0);
    check("idle_flush_result", bus.result, res_before);

    // Reset mid-shift
    bus.in_valid = 1'b1;
    bus.aluOp    = 4'b1101;
    bus.opA      = 32'h8000_0001;
    bus.opB      = 32'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid_result", bus.result, 32'd0);
    check("rstmid_zero", 32'(bus.zero), 32'd1);
    check("rstmid_ready", 32'(bus.in_ready), 32'd1);
    repeat (25) begin
      @(negedge clk);
      check("rstmid_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // Random ops, with a bias towards shifts and small operands
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom);
      if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b1101;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(op, ($urandom_range(0, 4) == 0) ? b : $urandom, b, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
